// File: rtl/priority_encoder_8to3.sv
// Registered priority encoder: reports the index of the highest set request bit plus a valid flag.
// One clock of latency; outputs clear asynchronously while rst_n is low.
module priority_encoder_8to3 #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned OUT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   output logic [OUT_W-1:0] out,
   output logic             valid
);

   logic [OUT_W-1:0] idx_d;
   logic             valid_d;

   // Upward scan: later (higher) set bits overwrite earlier ones, so the top bit wins.
   always_comb begin
      idx_d = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (in[i]) begin
            idx_d = OUT_W'(i);
         end
      end
      valid_d = |in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out   <= '0;
         valid <= 1'b0;
      end else begin
         out   <= idx_d;
         valid <= valid_d;
      end
   end

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Directed, table-driven bench for priority_encoder_8to3 with hand-computed expectations.
module tb_priority_encoder_8to3;

   logic       clk;
   logic       rst_n;
   logic [7:0] in;
   logic [2:0] out;
   logic       valid;

   int n_cmp;
   int n_bad;

   typedef struct {
      logic [7:0] vin;
      logic [2:0] eout;
      logic       evalid;
   } vec_t;

   vec_t vecs[16];

   priority_encoder_8to3 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in),
      .out   (out),
      .valid (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [2:0] eo, input logic ev);
      n_cmp++;
      if (out !== eo || valid !== ev) begin
         n_bad++;
         $display("FAIL %s: got out=%0d valid=%0b, want out=%0d valid=%0b", name, out, valid,
                  eo, ev);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;

      vecs[0]  = '{8'b0000_0000, 3'd0, 1'b0};
      vecs[1]  = '{8'b0000_0001, 3'd0, 1'b1};
      vecs[2]  = '{8'b0000_0010, 3'd1, 1'b1};
      vecs[3]  = '{8'b0000_0100, 3'd2, 1'b1};
      vecs[4]  = '{8'b0000_1000, 3'd3, 1'b1};
      vecs[5]  = '{8'b0001_0000, 3'd4, 1'b1};
      vecs[6]  = '{8'b0010_0000, 3'd5, 1'b1};
      vecs[7]  = '{8'b0100_0000, 3'd6, 1'b1};
      vecs[8]  = '{8'b1000_0000, 3'd7, 1'b1};
      vecs[9]  = '{8'b1111_1111, 3'd7, 1'b1};
      vecs[10] = '{8'b0001_0110, 3'd4, 1'b1};
      vecs[11] = '{8'b0000_0011, 3'd1, 1'b1};
      vecs[12] = '{8'b1000_0001, 3'd7, 1'b1};
      vecs[13] = '{8'b0000_0000, 3'd0, 1'b0};
      vecs[14] = '{8'b0110_0000, 3'd6, 1'b1};
      vecs[15] = '{8'b0000_1010, 3'd3, 1'b1};

      // Reset held with all requests active: outputs must be clear before any clock edge.
      rst_n = 1'b0;
      in    = 8'hFF;
      #2;
      check("reset_no_edge", 3'd0, 1'b0);
      @(posedge clk);
      #1;
      check("reset_held_edge", 3'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("release_before_edge", 3'd0, 1'b0);
      @(posedge clk);
      #1;
      check("release_first_edge", 3'd7, 1'b1);

      foreach (vecs[i]) begin
         @(negedge clk);
         in = vecs[i].vin;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_%b", i, vecs[i].vin), vecs[i].eout, vecs[i].evalid);
      end

      // Hold: a mid-cycle input change must not reach the outputs until the next edge.
      @(negedge clk);
      in = 8'b0000_0100;
      @(posedge clk);
      #1;
      check("hold_load", 3'd2, 1'b1);
      in = 8'b0000_0000;
      #3;
      check("hold_mid_cycle_zero", 3'd2, 1'b1);
      in = 8'b0010_0001;
      #3;
      check("hold_mid_cycle_new", 3'd2, 1'b1);
      @(posedge clk);
      #1;
      check("hold_next_edge", 3'd5, 1'b1);

      // Asynchronous mid-run reset while valid is high.
      #1;
      rst_n = 1'b0;
      #1;
      check("midrun_async_clear", 3'd0, 1'b0);
      @(posedge clk);
      #1;
      check("midrun_held", 3'd0, 1'b0);
      @(negedge clk);
      in    = 8'b0100_0000;
      rst_n = 1'b1;
      #1;
      check("midrun_release_no_edge", 3'd0, 1'b0);
      @(posedge clk);
      #1;
      check("midrun_resume", 3'd6, 1'b1);
      @(negedge clk);
      in = 8'b0000_0001;
      @(posedge clk);
      #1;
      check("midrun_bit0", 3'd0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
